// File: rtl/dds_tone_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dds_tone_pkg : shared types and constants for the keyed DDS tone generator
// Revision     : 1.0
// ----------------------------------------------------------------------------
package dds_tone_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    localparam int unsigned FS_DEFAULT  = 46875;
    // freq_incr for 1 Hz at FS_DEFAULT with a 32-bit accumulator
    localparam int unsigned INCR_PER_HZ = 91626;

    function automatic int unsigned env_max(input int unsigned env_w);
        return (32'd1 << env_w) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dds_sine_rom.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dds_sine_rom : combinational signed sine table, contents built at elaboration
// Revision     : 1.0
// ----------------------------------------------------------------------------
module dds_sine_rom #(
    parameter int TABLE_AW = 8,
    parameter int DATA_W   = 16
) (
    input  logic [TABLE_AW-1:0]      index,
    output logic signed [DATA_W-1:0] sample
);

    localparam int     DEPTH       = 1 << TABLE_AW;
    localparam int     QUARTER     = DEPTH / 4;
    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    // Integer Taylor series in Q30 keeps the table free of real arithmetic
    function automatic longint sine_q30(input longint k);
        longint x, t, acc;
        x   = (HALF_PI_Q30 * k) / longint'(QUARTER);
        t   = x;
        acc = x;
        for (int n = 1; n <= 8; n++) begin
            t   = (t * x) >>> 30;
            t   = (t * x) >>> 30;
            t   = -t / longint'((2 * n) * (2 * n + 1));
            acc = acc + t;
        end
        return acc;
    endfunction

    function automatic logic signed [DATA_W-1:0] sine_entry(input int i);
        int     quad;
        int     r;
        longint k, amp, mag;
        quad = i / QUARTER;
        r    = i % QUARTER;
        k    = ((quad % 2) == 1) ? longint'(QUARTER - r) : longint'(r);
        amp  = (longint'(1) << (DATA_W - 1)) - 1;
        mag  = (amp * sine_q30(k) + (longint'(1) << 29)) >>> 30;
        if (mag > amp) mag = amp;
        if (mag < 0)   mag = 0;
        return (quad >= 2) ? DATA_W'(-mag) : DATA_W'(mag);
    endfunction

    logic signed [DATA_W-1:0] w_table [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tab
            localparam logic signed [DATA_W-1:0] VAL = sine_entry(gi);
            assign w_table[gi] = VAL;
        end
    endgenerate

    assign sample = w_table[index];

endmodule
`default_nettype wire

// File: rtl/dds_keyed_tone.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dds_keyed_tone : DDS sine tone with click-free keyed attack/release envelope
// Option macro   : DDS_PHASE_RESET_EN (restart phase at zero on each keypress)
// Revision       : 1.0
// ----------------------------------------------------------------------------
module dds_keyed_tone
    import dds_tone_pkg::*;
#(
    parameter int PHASE_W   = 32,
    parameter int TABLE_AW  = 8,
    parameter int DATA_W    = 16,
    parameter int ENV_W     = 8,
    parameter int RAMP_STEP = 16
) (
    input  logic                      clk,
    input  logic                      AUD_DACLRCK,
    input  logic                      sample_tick,
    input  logic                      key,
    input  logic [PHASE_W-1:0]        freq_incr,
    input  logic [1:0]                ch_en,
    output logic signed [DATA_W-1:0]  audio_outL,
    output logic signed [DATA_W-1:0]  audio_outR,
    output logic                      busy,
    output logic [ENV_W-1:0]          env
);

    localparam int unsigned C_ENV_MAX = env_max(ENV_W);
    localparam int          PROD_W    = DATA_W + ENV_W + 1;

    env_state_t               r_state, w_state_nxt;
    logic [PHASE_W-1:0]       r_phase, w_phase_nxt;
    logic [ENV_W-1:0]         r_env, w_env_nxt;
    logic [31:0]              w_env_ext;
    logic                     w_up_sat, w_dn_zero;
    logic [ENV_W-1:0]         w_env_up, w_env_dn;
    logic signed [DATA_W-1:0] w_sine;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [DATA_W-1:0] w_scaled;

    dds_sine_rom #(
        .TABLE_AW (TABLE_AW),
        .DATA_W   (DATA_W)
    ) u_rom (
        .index  (r_phase[PHASE_W-1 -: TABLE_AW]),
        .sample (w_sine)
    );

    assign w_env_ext = 32'(r_env);
    assign w_up_sat  = (w_env_ext + 32'(RAMP_STEP)) >= C_ENV_MAX;
    assign w_dn_zero = w_env_ext <= 32'(RAMP_STEP);
    assign w_env_up  = ENV_W'(w_env_ext + 32'(RAMP_STEP));
    assign w_env_dn  = ENV_W'(w_env_ext - 32'(RAMP_STEP));

    // Envelope is zero-extended so full scale stays positive
    assign w_prod   = w_sine * $signed({1'b0, r_env});
    assign w_scaled = DATA_W'(w_prod >>> ENV_W);

    always_comb begin
        w_state_nxt = r_state;
        w_env_nxt   = r_env;
        w_phase_nxt = r_phase + freq_incr;
        case (r_state)
            IDLE: begin
                w_env_nxt = '0;
                if (key) begin
                    w_state_nxt = ATTACK;
`ifdef DDS_PHASE_RESET_EN
                    w_phase_nxt = '0;
`else
                    w_phase_nxt = r_phase + freq_incr;
`endif
                end
            end
            ATTACK: begin
                if (!key) begin
                    w_state_nxt = RELEASE;
                end else if (w_up_sat) begin
                    w_env_nxt   = '1;
                    w_state_nxt = SUSTAIN;
                end else begin
                    w_env_nxt   = w_env_up;
                end
            end
            SUSTAIN: begin
                w_env_nxt = '1;
                if (!key) begin
                    w_env_nxt   = w_dn_zero ? '0 : w_env_dn;
                    w_state_nxt = w_dn_zero ? IDLE : RELEASE;
                end
            end
            RELEASE: begin
                // Retrigger ramps up from wherever the release had reached
                if (key) begin
                    w_env_nxt   = w_up_sat ? '1 : w_env_up;
                    w_state_nxt = w_up_sat ? SUSTAIN : ATTACK;
                end else begin
                    w_env_nxt   = w_dn_zero ? '0 : w_env_dn;
                    w_state_nxt = w_dn_zero ? IDLE : RELEASE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_env_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge AUD_DACLRCK) begin
        if (!AUD_DACLRCK) begin
            r_state    <= IDLE;
            r_phase    <= '0;
            r_env      <= '0;
            audio_outL <= '0;
            audio_outR <= '0;
        end else if (sample_tick) begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_env      <= w_env_nxt;
            audio_outL <= ch_en[0] ? w_scaled : '0;
            audio_outR <= ch_en[1] ? w_scaled : '0;
        end
    end

    assign busy = (r_state != IDLE);
    assign env  = r_env;

endmodule
`default_nettype wire

// File: tb/tb_dds_keyed_tone.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dds_keyed_tone : directed, table-driven bench for dds_keyed_tone
// Revision          : 1.0
// ----------------------------------------------------------------------------
module tb_dds_keyed_tone;

    logic                clk = 1'b0;
    logic                AUD_DACLRCK;
    logic                sample_tick;
    logic                key;
    logic [31:0]         freq_incr;
    logic [1:0]          ch_en;
    logic signed [15:0]  audio_outL;
    logic signed [15:0]  audio_outR;
    logic                busy;
    logic [7:0]          env;

    always #5 clk = ~clk;

    dds_keyed_tone dut (
        .clk         (clk),
        .AUD_DACLRCK (AUD_DACLRCK),
        .sample_tick (sample_tick),
        .key         (key),
        .freq_incr   (freq_incr),
        .ch_en       (ch_en),
        .audio_outL  (audio_outL),
        .audio_outR  (audio_outR),
        .busy        (busy),
        .env         (env)
    );

    typedef struct {
        logic        k;
        logic [1:0]  ch;
        logic [31:0] f;
        int          e_env;
        int          e_busy;
        int          e_l;
        int          e_r;
    } vec_t;

    localparam logic [31:0] Q = 32'h4000_0000;

    vec_t vecs [32];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int e_env, input int e_busy,
                             input int e_l, input int e_r);
        check({name, " env"},  int'(env),        e_env);
        check({name, " busy"}, int'(busy),       e_busy);
        check({name, " L"},    int'(audio_outL), e_l);
        check({name, " R"},    int'(audio_outR), e_r);
    endtask

    task automatic tick(input logic k, input logic [1:0] ch, input logic [31:0] f);
        @(negedge clk);
        key         = k;
        ch_en       = ch;
        freq_incr   = f;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic setv(input int i, input logic k, input logic [1:0] ch, input logic [31:0] f,
                        input int e_env, input int e_l, input int e_r);
        vecs[i] = '{k, ch, f, e_env, 1, e_l, e_r};
    endtask

    initial begin
        int prev;
        int e;
        int o;

        // IDLE->ATTACK, ramp, sustain with phase parked at 0
        setv(0, 1'b1, 2'b11, 32'd0, 0, 0, 0);
        for (int i = 1; i <= 15; i++) setv(i, 1'b1, 2'b11, 32'd0, 16 * i, 0, 0);
        setv(16, 1'b1, 2'b11, 32'd0, 255, 0, 0);
        // quarter-turn waveform and channel gating
        setv(17, 1'b1, 2'b11, Q, 255, 0, 0);
        setv(18, 1'b1, 2'b11, Q, 255, 32639, 32639);
        setv(19, 1'b1, 2'b11, Q, 255, 0, 0);
        setv(20, 1'b1, 2'b11, Q, 255, -32640, -32640);
        setv(21, 1'b1, 2'b11, Q, 255, 0, 0);
        setv(22, 1'b1, 2'b10, Q, 255, 0, 32639);
        setv(23, 1'b1, 2'b10, Q, 255, 0, 0);
        setv(24, 1'b1, 2'b10, Q, 255, 0, -32640);
        setv(25, 1'b1, 2'b01, Q, 255, 0, 0);
        setv(26, 1'b1, 2'b01, Q, 255, 32639, 0);
        setv(27, 1'b1, 2'b11, Q, 255, 0, 0);
        // release for three ticks at index 192, then retrigger
        setv(28, 1'b0, 2'b11, 32'd0, 239, -32640, -32640);
        setv(29, 1'b0, 2'b11, 32'd0, 223, -30592, -30592);
        setv(30, 1'b0, 2'b11, 32'd0, 207, -28544, -28544);
        setv(31, 1'b1, 2'b11, 32'd0, 223, -26496, -26496);

        AUD_DACLRCK = 1'b0;
        sample_tick = 1'b0;
        key         = 1'b1;
        freq_incr   = Q;
        ch_en       = 2'b11;

        for (int i = 0; i < 3; i++) tick(1'b1, 2'b11, Q);
        check_all("reset_hold", 0, 0, 0, 0);
        @(negedge clk);
        AUD_DACLRCK = 1'b1;

        for (int i = 0; i < 32; i++) begin
            tick(vecs[i].k, vecs[i].ch, vecs[i].f);
            check_all($sformatf("vec%0d", i), vecs[i].e_env, vecs[i].e_busy,
                      vecs[i].e_l, vecs[i].e_r);
            if (i == 16) begin
                repeat (3) @(negedge clk);
                check_all("no_tick_hold", 255, 1, 0, 0);
            end
        end

        // ATTACK with key released holds the level, then release down to IDLE
        tick(1'b0, 2'b11, 32'd0);
        o = (-32767 * 223) >>> 8;
        check_all("attack_to_release", 223, 1, o, o);
        e = 223;
        while (e > 0) begin
            prev = e;
            e    = (e > 16) ? e - 16 : 0;
            tick(1'b0, 2'b11, 32'd0);
            o = (-32767 * prev) >>> 8;
            check_all($sformatf("release_%0d", e), e, (e != 0) ? 1 : 0, o, o);
        end
        tick(1'b0, 2'b11, 32'd0);
        check_all("idle_silent", 0, 0, 0, 0);

        // Re-ramp to SUSTAIN, then reset asynchronously mid-tone
        tick(1'b1, 2'b11, 32'd0);
        for (int i = 0; i < 16; i++) tick(1'b1, 2'b11, 32'd0);
        check("ramp2 env", int'(env), 255);
        tick(1'b1, 2'b11, 32'd0);
        check_all("sustain_tone", 255, 1, -32640, -32640);
        @(posedge clk);
        #2 AUD_DACLRCK = 1'b0;
        #1 check_all("async_reset", 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) tick(1'b1, 2'b11, Q);
        check_all("reset_ticks", 0, 0, 0, 0);
        @(negedge clk);
        AUD_DACLRCK = 1'b1;

        // From phase 0: freq 0 stays silent; then decrement across the wrap
        tick(1'b1, 2'b11, 32'd0);
        check_all("post_reset_attack", 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 2'b11, 32'd0);
            check("zero_freq L", int'(audio_outL), 0);
        end
        check("ramp3 env", int'(env), 255);
        tick(1'b1, 2'b11, 32'hFFFF_FFFF);
        check_all("wrap0", 255, 1, 0, 0);
        tick(1'b1, 2'b11, 32'hFFFF_FFFF);
        check_all("wrap1", 255, 1, -801, -801);
        tick(1'b1, 2'b11, 32'd1);
        check_all("wrap2", 255, 1, -801, -801);
        tick(1'b1, 2'b11, 32'd1);
        check_all("wrap3", 255, 1, -801, -801);
        tick(1'b1, 2'b11, 32'd0);
        check_all("wrap4", 255, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
